// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial framing path (transmitter, parity
// checker and any future receiver).
//   tx_state_e  : frame FSM state encoding
//   START_BIT / STOP_BIT / IDLE_LEVEL : line levels
//   frame_len() : number of line cycles per frame for a given data width
//   line_level(): serial line level driven in a given state
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Start + parity + stop framing around the data bits.
  localparam int unsigned FRAME_OVERHEAD = 32'd3;

  function automatic int unsigned frame_len(input int unsigned width);
    return width + FRAME_OVERHEAD;
  endfunction

  // Line level for a state; unknown encodings fall back to the idle level
  // so a corrupted state never drives a spurious start bit.
  function automatic logic line_level(input tx_state_e st,
                                      input logic      data_bit,
                                      input logic      parity_bit);
    logic lvl;
    case (st)
      IDLE:    lvl = IDLE_LEVEL;
      START:   lvl = START_BIT;
      DATA:    lvl = data_bit;
      PARITY:  lvl = parity_bit;
      STOP:    lvl = STOP_BIT;
      default: lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: accepts a parallel word over valid/ready and emits it as
// a framed serial stream: start bit, data LSB first, parity bit, stop bit.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   data_in      word to transmit (sampled only on accept)
//   data_valid   data_in valid this cycle
//   data_ready   accept happens at an edge where data_valid is also high
//   serial_bit   serial line, idles high
//   bit_valid    high for every bit of a frame
//   frame_start  one-cycle pulse with the start bit
//   busy         a frame is on the line
// Every output is a flop loaded from the next-state values, so outputs
// change on the same edge as the state and never depend on inputs
// combinationally.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e        state_q,       state_d;
  logic [WIDTH-1:0] shift_q,       shift_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             parity_q,      parity_d;
  logic             serial_bit_q,  serial_bit_d;
  logic             bit_valid_q,   bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q,        busy_d;
  logic             data_ready_q,  data_ready_d;
  logic             accept;

  // Handshake: ready is a registered decode of IDLE/STOP, so accept never
  // races the state it is about to change.
  assign accept = data_valid & data_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;

    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d  = START;
          shift_d  = data_in;
          cnt_d    = '0;
          parity_d = (^data_in) ^ ODD_PARITY;
        end else if (state_q == STOP) begin
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        // Bit 0 is on the line this cycle; expose the next one.
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase

    serial_bit_d  = line_level(state_d, shift_d[0], parity_d);
    bit_valid_d   = (state_d != IDLE);
    frame_start_d = (state_d == START);
    busy_d        = (state_d != IDLE);
    data_ready_d  = (state_d == IDLE) || (state_d == STOP);
  end

  // State, datapath and output flops; reset forces the idle line at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      parity_q      <= 1'b0;
      serial_bit_q  <= IDLE_LEVEL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      data_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      parity_q      <= parity_d;
      serial_bit_q  <= serial_bit_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign serial_bit  = serial_bit_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign data_ready  = data_ready_q;

endmodule
